divider_rr_param: RTL and testbench

Parametrised sequential radix-2 restoring divider, successor to the fixed 8/4 restoring-divider. Divides an L_DIVN-bit dividend by an L_DIVR-bit divisor with a per-operation signed/unsigned mode and fixed, data-independent latency. Flags divide-by-zero and signed overflow. Sits in the arithmetic datapath behind a start/ready/done handshake.

---
 rtl/divider_rr_param_if.sv | 26 ++
 rtl/divider_rr_param.sv | 129 ++++++++++++
 tb/tb_divider_rr_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/divider_rr_param_if.sv
// Start/ready/done handshake and operand/result bus for divider_rr_param.
interface divider_rr_param_if #(
  parameter int unsigned L_DIVN = 16,
  parameter int unsigned L_DIVR = 8
);
  logic              start;
  logic              signed_mode;
  logic [L_DIVN-1:0] word1;
  logic [L_DIVR-1:0] word2;
  logic [L_DIVN-1:0] quotient;
  logic [L_DIVR-1:0] remainder;
  logic              ready;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, signed_mode, word1, word2,
    input  quotient, remainder, ready, busy, done, error
  );

  modport slave (
    input  start, signed_mode, word1, word2,
    output quotient, remainder, ready, busy, done, error
  );
endinterface

// File: rtl/divider_rr_param.sv
// Parametrised radix-2 restoring divider, signed/unsigned per operation,
// fixed latency, with divide-by-zero and signed-overflow flags.
module divider_rr_param #(
  parameter int unsigned L_DIVN = 16,
  parameter int unsigned L_DIVR = 8
) (
  input  logic              clock,
  input  logic              reset,
  divider_rr_param_if.slave bus
);
  localparam int unsigned L_CNT = $clog2(L_DIVN + 1);
  localparam int unsigned L_PR  = L_DIVR + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_FIX  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [L_DIVN-1:0] qreg_q, qreg_d;
  logic [L_DIVR-1:0] dreg_q, dreg_d;
  logic [L_DIVR-1:0] pr_q, pr_d;
  logic [L_CNT-1:0]  cnt_q, cnt_d;
  logic              sign_q_q, sign_q_d;
  logic              sign_r_q, sign_r_d;
  logic [L_DIVN-1:0] quotient_q, quotient_d;
  logic [L_DIVR-1:0] remainder_q, remainder_d;

  logic [L_DIVN-1:0] w1_mag_c;
  logic [L_DIVR-1:0] w2_mag_c;
  logic [L_PR-1:0]   trial_c;
  logic              ovf_c;

  // Operand magnitudes; the two's-complement minimum maps onto its own unsigned value.
  assign w1_mag_c = (bus.signed_mode && bus.word1[L_DIVN-1]) ? L_DIVN'(-bus.word1) : bus.word1;
  assign w2_mag_c = (bus.signed_mode && bus.word2[L_DIVR-1]) ? L_DIVR'(-bus.word2) : bus.word2;
  assign ovf_c    = bus.signed_mode && (bus.word1 == {1'b1, {(L_DIVN-1){1'b0}}})
                    && (bus.word2 == {L_DIVR{1'b1}});
  assign trial_c  = {pr_q, qreg_q[L_DIVN-1]} - {1'b0, dreg_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      qreg_q      <= '0;
      dreg_q      <= '0;
      pr_q        <= '0;
      cnt_q       <= '0;
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      qreg_q      <= qreg_d;
      dreg_q      <= dreg_d;
      pr_q        <= pr_d;
      cnt_q       <= cnt_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    qreg_d      = qreg_q;
    dreg_d      = dreg_q;
    pr_d        = pr_q;
    cnt_d       = cnt_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word2 == '0) begin
            state_d     = S_ERR;
            quotient_d  = '1;
            remainder_d = '0;
          end else if (ovf_c) begin
            state_d     = S_ERR;
            quotient_d  = {1'b1, {(L_DIVN-1){1'b0}}};
            remainder_d = '0;
          end else begin
            state_d  = S_DIV;
            qreg_d   = w1_mag_c;
            dreg_d   = w2_mag_c;
            pr_d     = '0;
            cnt_d    = '0;
            sign_q_d = bus.signed_mode && (bus.word1[L_DIVN-1] ^ bus.word2[L_DIVR-1]);
            sign_r_d = bus.signed_mode && bus.word1[L_DIVN-1];
          end
        end
      end
      S_DIV: begin
        // Partial remainder stays below the divisor, so L_DIVR bits hold it after each step.
        if (!trial_c[L_DIVR]) begin
          pr_d   = trial_c[L_DIVR-1:0];
          qreg_d = {qreg_q[L_DIVN-2:0], 1'b1};
        end else begin
          pr_d   = {pr_q[L_DIVR-2:0], qreg_q[L_DIVN-1]};
          qreg_d = {qreg_q[L_DIVN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == L_CNT'(L_DIVN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = sign_q_q ? L_DIVN'(-qreg_q) : qreg_q;
        remainder_d = sign_r_q ? L_DIVR'(-pr_q) : pr_q;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ready     = (state_q == S_IDLE) && !reset;
  assign bus.busy      = (state_q == S_DIV) || (state_q == S_FIX);
  assign bus.done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.error     = (state_q == S_ERR);
endmodule

// File: tb/tb_divider_rr_param.sv
// Self-checking bench for divider_rr_param at L_DIVN=8, L_DIVR=4: directed
// cases plus random operands checked against an integer-arithmetic model.
module tb_divider_rr_param;
  localparam int unsigned N = 8;
  localparam int unsigned R = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ndone;

  always #5 clock = ~clock;

  divider_rr_param_if #(.L_DIVN(N), .L_DIVR(R)) bus ();

  divider_rr_param #(.L_DIVN(N), .L_DIVR(R)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder follows dividend).
  function automatic void model(input logic sm, input logic [N-1:0] a, input logic [R-1:0] b,
                                output logic [N-1:0] q, output logic [R-1:0] r, output logic e);
    int n, d, qi, ri;
    n = sm ? int'($signed(a)) : int'(a);
    d = sm ? int'($signed(b)) : int'(b);
    if (d == 0) begin
      q = '1; r = '0; e = 1'b1;
    end else if (sm && n == -(2 ** (N - 1)) && d == -1) begin
      q = N'(2 ** (N - 1)); r = '0; e = 1'b1;
    end else begin
      qi = n / d;
      ri = n % d;
      q  = N'(qi);
      r  = R'(ri);
      e  = 1'b0;
    end
  endfunction

  // Called at a negedge while idle; returns at the negedge of the first ready cycle.
  task automatic do_op(input logic sm, input logic [N-1:0] a, input logic [R-1:0] b,
                       input string tag);
    logic [N-1:0] eq;
    logic [R-1:0] er;
    logic         ee;
    int           lat;
    model(sm, a, b, eq, er, ee);
    check({tag, ".ready_in"}, 32'(bus.ready), 32'd1);
    bus.signed_mode = sm;
    bus.word1       = a;
    bus.word2       = b;
    bus.start       = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      bus.start = 1'b0;
      lat++;
    end while (!bus.done && lat < 40);
    check({tag, ".latency"}, 32'(lat), ee ? 32'd1 : 32'(N + 2));
    check({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
    check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, ".error"}, 32'(bus.error), 32'(ee));
    @(negedge clock);
    check({tag, ".done_width"}, 32'(bus.done), 32'd0);
    check({tag, ".ready_out"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.word1       = '0;
    bus.word2       = '0;

    // Reset state
    #2;
    check("rst.quotient", 32'(bus.quotient), 32'd0);
    check("rst.remainder", 32'(bus.remainder), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.error", 32'(bus.error), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.ready", 32'(bus.ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst.ready_release", 32'(bus.ready), 32'd1);
    @(negedge clock);

    // Directed cases
    do_op(1'b0, 8'd200, 4'd7, "u200_7");
    do_op(1'b1, 8'h9C, 4'h7, "s_m100_7");
    do_op(1'b1, 8'h64, 4'h9, "s_100_m7");
    do_op(1'b1, 8'h80, 4'h8, "s_m128_m8");
    do_op(1'b0, 8'h55, 4'h0, "dz_u");
    do_op(1'b1, 8'h55, 4'h0, "dz_s");
    do_op(1'b0, 8'd200, 4'd7, "after_dz");
    do_op(1'b1, 8'h80, 4'hF, "ovf_s");
    do_op(1'b0, 8'h80, 4'hF, "ovf_u");
    do_op(1'b0, 8'd255, 4'd1, "u255_1");
    do_op(1'b0, 8'd0, 4'd5, "u0_5");
    do_op(1'b0, 8'd14, 4'd15, "u14_15");
    do_op(1'b1, 8'h7F, 4'h8, "s_127_m8");

    // Starts during a busy operation are ignored
    bus.signed_mode = 1'b0;
    bus.word1       = 8'd200;
    bus.word2       = 4'd7;
    bus.start       = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3 || c == 5) begin
        bus.start = 1'b1;
        bus.word1 = 8'h55;
        bus.word2 = 4'h0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    check("busy_start.ndone", 32'(ndone), 32'd1);
    check("busy_start.quotient", 32'(bus.quotient), 32'h1C);
    check("busy_start.remainder", 32'(bus.remainder), 32'h4);
    check("busy_start.error", 32'(bus.error), 32'd0);

    // Reset mid-operation
    bus.word1 = 8'd200;
    bus.word2 = 4'd7;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst.quotient", 32'(bus.quotient), 32'd0);
    check("midrst.remainder", 32'(bus.remainder), 32'd0);
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.ready", 32'(bus.ready), 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.done) ndone++;
    end
    check("midrst.no_done", 32'(ndone), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst.ready_release", 32'(bus.ready), 32'd1);
    @(negedge clock);
    do_op(1'b0, 8'd200, 4'd7, "post_rst");

    // Random operands against the model
    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom), N'($urandom), R'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
